spi_master_seq: RTL
===================

# spi_master_seq

SPI mode-0 master transaction sequencer. It generates `sclk` and `ss_n` from `clk`, and emits the load and shift enables that drive the transmit PISO shift register and the receive SIPO shift register (`ShiftRegSIPOIzq`-style, `LARGO`-bit). It sits between the host-side start/done handshake and the SPI shift datapath. It holds no data itself; it only sequences.

## Interface
- `LARGO`, 8: bits per transfer; must be ≥ 2.
- `DIV`, 2: `clk` cycles per `sclk` half-period; must be ≥ 1.

- `clk`: in, 1. Single clock. All state updates on rising edge.
- `rst`: in, 1. Asynchronous, active-high reset.
- `start`: in, 1. Transfer request. Sampled only in IDLE.
- `abort`: in, 1. Synchronous cancel of the transfer in progress.
- `busy`: out, 1. High while a transfer is in progress.
- `done`: out, 1. One-cycle pulse on normal completion.
- `sclk`: out, 1. SPI clock. Idles low (CPOL=0).
- `ss_n`: out, 1. Slave select, active low.
- `ld_tx`: out, 1. Parallel-load pulse for the TX shift register.
- `ena_tx`: out, 1. Shift pulse for the TX shift register (next MOSI bit).
- `ena_rx`: out, 1. Shift pulse for the RX SIPO (capture MISO).

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, DONE.
- Reset values of all registered outputs: `busy`=0, `done`=0, `sclk`=0, `ss_n`=1, `ld_tx`=0, `ena_tx`=0, `ena_rx`=0. Internal state is IDLE with counters cleared.
- IDLE: `start`=1 moves to SETUP.
- SETUP: lasts DIV cycles. `ss_n`=0, `sclk`=0. `ld_tx`=1 in the first SETUP cycle only. Then moves to HIGH.
- HIGH: lasts DIV cycles with `sclk`=1. `ena_rx`=1 in the first HIGH cycle. The bit counter increments at the end of each HIGH phase. Then moves to LOW.
- LOW: lasts DIV cycles with `sclk`=0.
  - If bits remain, `ena_tx`=1 in the first LOW cycle and the next state is HIGH.
  - After bit LARGO, the state moves straight to HOLD instead; no `ena_tx` is issued for the final bit.
- HOLD: lasts DIV cycles. `ss_n`=0, `sclk`=0. Then moves to DONE.
- DONE: lasts 1 cycle. `done`=1, `busy`=0, `ss_n`=1. Then moves to IDLE.
- `busy`=1 in SETUP, HIGH, LOW and HOLD; 0 otherwise.
- Pulse counts per transfer: `ld_tx` 1, `ena_rx` LARGO, `ena_tx` LARGO−1, `sclk` rising edges LARGO.
- `start` is ignored in all states except IDLE, including DONE. A request asserted during DONE must be re-presented in IDLE.
- `abort`=1 in SETUP/HIGH/LOW/HOLD: next state is IDLE. All outputs return to their reset values on the next cycle, and no `done` is issued. `abort` in IDLE or DONE has no effect.
- `abort` and `start` asserted together in IDLE: the transfer starts (abort has no effect in IDLE).
- Counter widths: the divider counter covers 0..DIV−1 and the bit counter covers 0..LARGO. Neither counter wraps within a transfer; both clear on entry to SETUP.
- `rst` asserted mid-transfer forces reset values immediately (asynchronously), with no `done`.

## Timing
- Cycle 0 is the first SETUP cycle, i.e. the cycle after `start` is sampled.
- HIGH phase for bit k (k=0..LARGO−1) starts at cycle DIV + 2·DIV·k.
- HOLD starts at cycle DIV + 2·DIV·LARGO. DONE occurs at cycle 2·DIV + 2·DIV·LARGO.
- Busy length is 2·DIV·(LARGO+1) cycles. For the defaults this is 36 cycles, with `done` at cycle 36.
- All outputs are registered: glitch-free and aligned to `clk` rising edges.
- Each enable is exactly one `clk` cycle wide. Downstream shift registers clocked on the falling edge of `clk` sample each enable mid-cycle.
- MOSI is valid for DIV cycles before each `sclk` rise. MISO is captured at the first HIGH cycle.
- Back-to-back transfers: minimum `ss_n`-high time is 2 cycles (DONE + IDLE).

## Test plan
- Defaults (LARGO=8, DIV=2), single `start` pulse:
  - `busy` high for 36 cycles, then `done` at cycle 36.
  - 8 `sclk` periods of 4 cycles each.
  - `ld_tx`×1 at cycle 0; `ena_rx`×8 at cycles 2,6,…,30; `ena_tx`×7 at cycles 4,8,…,28.
- Loopback: controller + PISO + SIPO with MOSI tied to MISO.
  - TX 8'hA5 gives RX 8'hA5 at `done`.
  - Repeat with 8'h3C gives RX 8'h3C.
- Ignored starts:
  - `start` held high through an entire transfer yields exactly one `done`.
  - A `start` pulse in the DONE cycle only is ignored: `busy` stays 0.
- Abort in the 3rd HIGH phase:
  - Next cycle: `sclk`=0, `ss_n`=1, `busy`=0.
  - No `done`; `ena_rx` count is 3.
- Asynchronous `rst` at cycle 15 of a transfer:
  - All outputs take reset values before the next `clk` edge.
  - A subsequent `start` yields a full, correct 36-cycle transfer.
- Parameter sweep: DIV=1, LARGO=2, then DIV=3, LARGO=16.
  - `busy` length 6 and 102 cycles respectively.
  - Pulse counts per the Operation section.

Source files
------------

// File: rtl/spi_master_seq.sv
// -----------------------------------------------------------------------------
// spi_master_seq
//
// SPI mode-0 (CPOL=0, CPHA=0) master transaction sequencer. Generates sclk and
// ss_n from clk and emits the one-cycle load/shift enables for an external TX
// PISO and RX SIPO shift register. Holds no data; it only sequences.
//
// Parameters
//   LARGO : bits per transfer (>= 2)
//   DIV   : clk cycles per sclk half-period (>= 1)
//
// Ports
//   clk    in  : single clock, rising-edge
//   rst    in  : asynchronous active-high reset
//   start  in  : transfer request, sampled only in IDLE
//   abort  in  : synchronous cancel of a transfer in progress
//   busy   out : high while a transfer is in progress
//   done   out : one-cycle pulse on normal completion
//   sclk   out : SPI clock, idles low
//   ss_n   out : slave select, active low
//   ld_tx  out : parallel-load pulse for the TX shift register
//   ena_tx out : shift pulse for the TX shift register (next MOSI bit)
//   ena_rx out : shift pulse for the RX shift register (capture MISO)
// -----------------------------------------------------------------------------
module spi_master_seq #(
  parameter int LARGO = 8,
  parameter int DIV   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic sclk,
  output logic ss_n,
  output logic ld_tx,
  output logic ena_tx,
  output logic ena_rx
);

  // A DIV of 1 still needs a one-bit divider counter (it simply stays at 0).
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(LARGO + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(LARGO);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   div_reg, div_next;
  logic [BW-1:0]   bit_reg, bit_next;
  logic            phase_end;
  logic            first_next;

  logic busy_next, done_next, sclk_next, ss_n_next;
  logic ld_tx_next, ena_tx_next, ena_rx_next;

  assign phase_end = (div_reg == DIV_LAST);

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SETUP;
          div_next   = '0;
          bit_next   = '0;
        end
      end

      SETUP, HIGH, LOW, HOLD: begin
        if (abort) begin
          state_next = IDLE;
          div_next   = '0;
          bit_next   = '0;
        end else if (!phase_end) begin
          div_next = div_reg + 1'b1;
        end else begin
          div_next = '0;
          if (state_reg == SETUP) begin
            state_next = HIGH;
          end else if (state_reg == HIGH) begin
            state_next = LOW;
            bit_next   = bit_reg + 1'b1;
          end else if (state_reg == LOW) begin
            // The last LOW phase still runs its full length so that the final
            // sclk period is complete before slave select is held off.
            state_next = (bit_reg == BIT_LAST) ? HOLD : HIGH;
          end else begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        div_next   = '0;
        bit_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the *next* state so every output is a flop aligned with
  // the state it describes (no combinational paths to the pins).
  // ---------------------------------------------------------------------------
  always_comb begin
    first_next  = (div_next == '0);
    busy_next   = (state_next == SETUP) || (state_next == HIGH) ||
                  (state_next == LOW)   || (state_next == HOLD);
    done_next   = (state_next == DONE);
    sclk_next   = (state_next == HIGH);
    ss_n_next   = !busy_next;
    ld_tx_next  = (state_next == SETUP) && first_next;
    ena_rx_next = (state_next == HIGH) && first_next;
    // bit_next already counts the bit just sampled; no shift after the last one.
    ena_tx_next = (state_next == LOW) && first_next && (bit_next != BIT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      sclk   <= 1'b0;
      ss_n   <= 1'b1;
      ld_tx  <= 1'b0;
      ena_tx <= 1'b0;
      ena_rx <= 1'b0;
    end else begin
      busy   <= busy_next;
      done   <= done_next;
      sclk   <= sclk_next;
      ss_n   <= ss_n_next;
      ld_tx  <= ld_tx_next;
      ena_tx <= ena_tx_next;
      ena_rx <= ena_rx_next;
    end
  end

endmodule
